mem_access_unit: RTL and testbench

MEM-stage consumer of the EX/MEM pipeline register outputs. It executes loads and stores against a variable-latency data memory using a req/ack handshake, and freezes the upstream pipeline with stall_o while an access is outstanding. It delivers registered results to the MEM/WB register. A watchdog aborts hung accesses and sets a sticky error flag.

---
 rtl/mem_access_unit.sv | 189 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: drives a req/ack data memory, stalls upstream while an
// access is outstanding, registers results toward MEM/WB and aborts hung accesses.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        RegWrite_i,
    input  logic        MemtoReg_i,
    input  logic        MemWrite_i,
    input  logic        ExtOp_i,
    input  logic [31:0] ALUdata_i,
    input  logic [31:0] Write_data_i,
    input  logic [4:0]  instr_i,
    output logic        stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        RegWrite_o,
    output logic        MemtoReg_o,
    output logic        ExtOp_o,
    output logic [31:0] ALUdata_o,
    output logic [31:0] Read_data_o,
    output logic [4:0]  instr_o,
    output logic        err_o
);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_t;

    state_t             r_state, w_state_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;
    logic               r_req, w_req_next;
    logic               r_we, w_we_next;
    logic [31:0]        r_addr, w_addr_next;
    logic [31:0]        r_wdata, w_wdata_next;
    logic               r_lat_regwrite, w_lat_regwrite_next;
    logic               r_lat_memtoreg, w_lat_memtoreg_next;
    logic               r_lat_extop, w_lat_extop_next;
    logic [4:0]         r_lat_instr, w_lat_instr_next;
    logic               r_regwrite, w_regwrite_next;
    logic               r_memtoreg, w_memtoreg_next;
    logic               r_extop, w_extop_next;
    logic [31:0]        r_aludata, w_aludata_next;
    logic [31:0]        r_rdata, w_rdata_next;
    logic [4:0]         r_instr, w_instr_next;
    logic               r_err, w_err_next;
    logic               w_stall;
    logic               w_access;
    logic               w_timeout_hit;

    assign w_access      = MemtoReg_i | MemWrite_i;
    assign w_timeout_hit = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Next-state, stall and next-output computation; every register holds by default.
    always_comb begin
        w_state_next        = r_state;
        w_cnt_next          = r_cnt;
        w_req_next          = r_req;
        w_we_next           = r_we;
        w_addr_next         = r_addr;
        w_wdata_next        = r_wdata;
        w_lat_regwrite_next = r_lat_regwrite;
        w_lat_memtoreg_next = r_lat_memtoreg;
        w_lat_extop_next    = r_lat_extop;
        w_lat_instr_next    = r_lat_instr;
        w_regwrite_next     = r_regwrite;
        w_memtoreg_next     = r_memtoreg;
        w_extop_next        = r_extop;
        w_aludata_next      = r_aludata;
        w_rdata_next        = r_rdata;
        w_instr_next        = r_instr;
        w_err_next          = r_err;
        w_stall             = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_access) begin
                    w_stall             = 1'b1;
                    w_state_next        = ST_WAIT;
                    w_cnt_next          = {CNT_W{1'b0}};
                    w_req_next          = 1'b1;
                    w_we_next           = MemWrite_i;
                    w_addr_next         = ALUdata_i;
                    w_wdata_next        = Write_data_i;
                    w_lat_regwrite_next = RegWrite_i;
                    w_lat_memtoreg_next = MemtoReg_i;
                    w_lat_extop_next    = ExtOp_i;
                    w_lat_instr_next    = instr_i;
                    w_regwrite_next     = 1'b0;
                    w_memtoreg_next     = 1'b0;
                end else begin
                    w_regwrite_next = RegWrite_i;
                    w_memtoreg_next = MemtoReg_i;
                    w_extop_next    = ExtOp_i;
                    w_aludata_next  = ALUdata_i;
                    w_instr_next    = instr_i;
                end
            end
            ST_WAIT: begin
                // Ack has priority over a coincident timeout.
                if (mem_ack_i) begin
                    w_state_next    = ST_IDLE;
                    w_req_next      = 1'b0;
                    w_regwrite_next = r_lat_regwrite;
                    w_memtoreg_next = r_lat_memtoreg;
                    w_extop_next    = r_lat_extop;
                    w_aludata_next  = r_addr;
                    w_instr_next    = r_lat_instr;
                    if (!r_we) begin
                        w_rdata_next = mem_rdata_i;
                    end else begin
                        w_rdata_next = r_rdata;
                    end
                end else if (w_timeout_hit) begin
                    w_state_next    = ST_IDLE;
                    w_req_next      = 1'b0;
                    w_err_next      = 1'b1;
                    w_regwrite_next = 1'b0;
                    w_memtoreg_next = 1'b0;
                end else begin
                    w_stall    = 1'b1;
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_req_next   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state        <= ST_IDLE;
            r_cnt          <= {CNT_W{1'b0}};
            r_req          <= 1'b0;
            r_we           <= 1'b0;
            r_addr         <= 32'h0;
            r_wdata        <= 32'h0;
            r_lat_regwrite <= 1'b0;
            r_lat_memtoreg <= 1'b0;
            r_lat_extop    <= 1'b0;
            r_lat_instr    <= 5'h0;
            r_regwrite     <= 1'b0;
            r_memtoreg     <= 1'b0;
            r_extop        <= 1'b0;
            r_aludata      <= 32'h0;
            r_rdata        <= 32'h0;
            r_instr        <= 5'h0;
            r_err          <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_cnt          <= w_cnt_next;
            r_req          <= w_req_next;
            r_we           <= w_we_next;
            r_addr         <= w_addr_next;
            r_wdata        <= w_wdata_next;
            r_lat_regwrite <= w_lat_regwrite_next;
            r_lat_memtoreg <= w_lat_memtoreg_next;
            r_lat_extop    <= w_lat_extop_next;
            r_lat_instr    <= w_lat_instr_next;
            r_regwrite     <= w_regwrite_next;
            r_memtoreg     <= w_memtoreg_next;
            r_extop        <= w_extop_next;
            r_aludata      <= w_aludata_next;
            r_rdata        <= w_rdata_next;
            r_instr        <= w_instr_next;
            r_err          <= w_err_next;
        end
    end

    assign stall_o     = w_stall;
    assign mem_req_o   = r_req;
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign RegWrite_o  = r_regwrite;
    assign MemtoReg_o  = r_memtoreg;
    assign ExtOp_o     = r_extop;
    assign ALUdata_o   = r_aludata;
    assign Read_data_o = r_rdata;
    assign instr_o     = r_instr;
    assign err_o       = r_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed and randomized loads, stores and
// ALU ops against a transaction-level model with a configurable-latency memory.
module tb_mem_access_unit;

    localparam int T = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        RegWrite_i, MemtoReg_i, MemWrite_i, ExtOp_i;
    logic [31:0] ALUdata_i, Write_data_i;
    logic [4:0]  instr_i;
    logic        stall_o, mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        RegWrite_o, MemtoReg_o, ExtOp_o;
    logic [31:0] ALUdata_o, Read_data_o;
    logic [4:0]  instr_o;
    logic        err_o;

    mem_access_unit #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .RegWrite_i(RegWrite_i), .MemtoReg_i(MemtoReg_i), .MemWrite_i(MemWrite_i),
        .ExtOp_i(ExtOp_i), .ALUdata_i(ALUdata_i), .Write_data_i(Write_data_i),
        .instr_i(instr_i), .stall_o(stall_o), .mem_req_o(mem_req_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .RegWrite_o(RegWrite_o), .MemtoReg_o(MemtoReg_o), .ExtOp_o(ExtOp_o),
        .ALUdata_o(ALUdata_o), .Read_data_o(Read_data_o), .instr_o(instr_o),
        .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    // full=0 is a bubble: only RegWrite/MemtoReg (must be 0), Read_data and err are checked.
    typedef struct {
        bit          full;
        logic        rw;
        logic        mtr;
        logic        ext;
        logic [31:0] alu;
        logic [4:0]  ins;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] m_rdata = 32'h0;
    logic        m_err   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input bit full, input logic rw, input logic mtr, input logic ext,
                        input logic [31:0] alu, input logic [4:0] ins);
        exp_t e;
        e.full = full; e.rw = full ? rw : 1'b0; e.mtr = full ? mtr : 1'b0;
        e.ext = ext; e.alu = alu; e.ins = ins; e.rdata = m_rdata; e.err = m_err;
        sb_q.push_back(e);
    endtask

    // Monitor: one expected record per edge at which the bench issued something.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("out_RegWrite", {31'h0, RegWrite_o}, {31'h0, e.rw});
                check("out_MemtoReg", {31'h0, MemtoReg_o}, {31'h0, e.mtr});
                check("out_Read_data", Read_data_o, e.rdata);
                check("out_err", {31'h0, err_o}, {31'h0, e.err});
                if (e.full) begin
                    check("out_ExtOp", {31'h0, ExtOp_o}, {31'h0, e.ext});
                    check("out_ALUdata", ALUdata_o, e.alu);
                    check("out_instr", {27'h0, instr_o}, {27'h0, e.ins});
                end
            end
        end
    end

    // One instruction; d = WAIT cycles without ack before the ack, d >= T never acks.
    task automatic run_op(input logic rw, input logic mtr, input logic mw, input logic ext,
                          input logic [31:0] alu, input logic [31:0] wd,
                          input logic [4:0] ins, input int d);
        bit          done;
        logic        ack;
        logic [31:0] rd;
        @(negedge clk_i);
        RegWrite_i = rw; MemtoReg_i = mtr; MemWrite_i = mw; ExtOp_i = ext;
        ALUdata_i = alu; Write_data_i = wd; instr_i = ins; mem_ack_i = 1'b0;
        #1;
        if (!(mtr | mw)) begin
            check("stall_pass", {31'h0, stall_o}, 32'h0);
            push(1'b1, rw, mtr, ext, alu, ins);
            @(posedge clk_i);
        end else begin
            check("stall_accept", {31'h0, stall_o}, 32'h1);
            push(1'b0, rw, mtr, ext, alu, ins);
            @(posedge clk_i);
            done = 1'b0;
            for (int k = 0; k < T && !done; k++) begin
                @(negedge clk_i);
                ack = (k == d);
                rd  = $urandom;
                mem_ack_i = ack; mem_rdata_i = rd;
                #1;
                check("req_held", {31'h0, mem_req_o}, 32'h1);
                check("we_held", {31'h0, mem_we_o}, {31'h0, mw});
                check("addr_held", mem_addr_o, alu);
                check("wdata_held", mem_wdata_o, wd);
                check("stall_wait", {31'h0, stall_o}, {31'h0, (!ack && k != T - 1)});
                if (ack) begin
                    if (!mw) m_rdata = rd;
                    push(1'b1, rw, mtr, ext, alu, ins);
                    done = 1'b1;
                end else if (k == T - 1) begin
                    m_err = 1'b1;
                    push(1'b0, rw, mtr, ext, alu, ins);
                    done = 1'b1;
                end else begin
                    push(1'b0, rw, mtr, ext, alu, ins);
                end
                @(posedge clk_i);
            end
            #2;
            check("req_drop", {31'h0, mem_req_o}, 32'h0);
            mem_ack_i = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_outs"}, {RegWrite_o, MemtoReg_o, ExtOp_o, err_o, mem_req_o, mem_we_o},
              32'h0);
        check({name, "_alu"}, ALUdata_o, 32'h0);
        check({name, "_rdata"}, Read_data_o, 32'h0);
        check({name, "_instr"}, {27'h0, instr_o}, 32'h0);
        check({name, "_addr"}, mem_addr_o | mem_wdata_o, 32'h0);
    endtask

    initial begin
        rst_i = 1'b1; RegWrite_i = 1'b0; MemtoReg_i = 1'b0; MemWrite_i = 1'b0;
        ExtOp_i = 1'b0; ALUdata_i = 32'h0; Write_data_i = 32'h0; instr_i = 5'h0;
        mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
        repeat (2) @(posedge clk_i);
        #2;
        check_all_zero("reset");
        check("reset_stall", {31'h0, stall_o}, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;

        run_op(1'b1, 1'b0, 1'b0, 1'b1, 32'h1234, 32'h0, 5'd5, 0);     // ALU passthrough
        run_op(1'b1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 5'd7, 0);       // zero-wait load
        run_op(1'b0, 1'b0, 1'b1, 1'b0, 32'h80, 32'hCAFE, 5'd0, 2);    // slow store
        run_op(1'b1, 1'b1, 1'b1, 1'b1, 32'h90, 32'h5555, 5'd3, 1);    // both set: store
        run_op(1'b1, 1'b1, 1'b0, 1'b1, 32'hA0, 32'h0, 5'd9, T - 1);   // ack on timeout cycle
        run_op(1'b1, 1'b1, 1'b0, 1'b0, 32'hB0, 32'h0, 5'd11, T);      // timeout
        run_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h777, 32'h0, 5'd12, 0);     // ALU after timeout

        for (int i = 0; i < 60; i++) begin
            logic mtr, mw;
            mtr = ($urandom_range(0, 2) == 0);
            mw  = ($urandom_range(0, 2) == 0);
            run_op(1'($urandom), mtr, mw, 1'($urandom), $urandom, $urandom,
                   5'($urandom), $urandom_range(0, T));
        end

        // Reset in the middle of WAIT, followed by a late ack in IDLE.
        @(negedge clk_i);
        RegWrite_i = 1'b1; MemtoReg_i = 1'b1; MemWrite_i = 1'b0; ALUdata_i = 32'hC0;
        instr_i = 5'd4; mem_ack_i = 1'b0;
        push(1'b0, 1'b1, 1'b1, 1'b0, 32'hC0, 5'd4);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #2;
        check_all_zero("midwait_reset");
        m_rdata = 32'h0; m_err = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0; RegWrite_i = 1'b0; MemtoReg_i = 1'b0; ExtOp_i = 1'b0;
        ALUdata_i = 32'h0; instr_i = 5'h0; mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;
        #1;
        check("late_ack_stall", {31'h0, stall_o}, 32'h0);
        @(posedge clk_i);
        #2;
        check_all_zero("late_ack");
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        run_op(1'b1, 1'b0, 1'b0, 1'b1, 32'h4321, 32'h0, 5'd30, 0);
        repeat (3) @(posedge clk_i);
        #2;
        check("queue_drain", sb_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation time limit");
    end

endmodule
